// File: rtl/regfile_pkg.sv
// Shared definitions for the pipelined core's integer register file.
// Decode and writeback import the same XLEN/NREG defaults so that the widths
// on both sides of the file always agree.
package regfile_pkg;

  // Default data width and register count for the pipelined core.
  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;

  // Register 0 is hardwired to zero. Writes to it and scoreboard sets on it
  // are dropped.
  localparam int REG_ZERO = 0;

  // After reset the file first zeroes every entry (CLEAR). It then stays in
  // RUN until the next reset.
  typedef enum logic {
    CLEAR,
    RUN
  } rf_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One read port of the register file. It applies the zero-register rule,
// the optional write-to-read bypass, and busy masking to the raw array and
// scoreboard values that the top module supplies.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int AW     = $clog2(NREG_DEFAULT),
  parameter bit BYPASS = 1'b1
) (
  input  logic            ready,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] rdata,
  input  logic            busy_bit,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rd,
  output logic            busy
);

  logic hit;
  logic use_bypass;

  // Resolve the read data and busy flag for this port in the same cycle.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the block
    // can leave a value held and infer a latch.
    rd         = '0;
    busy       = 1'b0;
    hit        = ready && we && (waddr == addr) && (waddr != AW'(REG_ZERO));
    use_bypass = BYPASS && hit;
    if (ready && (addr != AW'(REG_ZERO))) begin
      rd   = use_bypass ? wdata : rdata;
      // A producer that retires this cycle is no longer a hazard once its
      // result is forwarded.
      busy = busy_bit && !use_bypass;
    end
  end

endmodule : regfile_read_port

// File: rtl/regfile_sb.sv
// Integer register file for the pipelined core. It has two combinational
// read ports and one write port, a hardwired-zero register 0, an optional
// write-to-read bypass, a sequenced post-reset clear, and a busy-bit
// scoreboard that decode sets and writeback clears.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  XLEN   = XLEN_DEFAULT,
  parameter int  NREG   = NREG_DEFAULT,
  parameter bit  BYPASS = 1'b1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we3,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] wd3,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_addr,
  output logic            busy1,
  output logic            busy2,
  output logic            ready
);

  rf_state_t       state;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;

  logic            wr_en;
  logic            set_en;

  // Writes and scoreboard sets count only in RUN, and never for register 0.
  assign wr_en  = (state == RUN) && we3    && (a3      != AW'(REG_ZERO));
  assign set_en = (state == RUN) && sb_set && (sb_addr != AW'(REG_ZERO));

  // Clear-sequence controller. Walk cnt through every entry, then enter RUN
  // and raise ready.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples pre-edge values no matter how the statements are ordered.
    if (!rst) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else if (state == CLEAR) begin
      cnt <= cnt + AW'(1);
      if (cnt == AW'(NREG - 1)) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end
  end

  // Register array. During CLEAR it is zeroed one entry per cycle; in RUN it
  // takes writeback data.
  // NOTE: the array has no reset branch. The CLEAR sequence gives it defined
  // contents, so it can still map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      mem[a3] <= wd3;
    end
  end

  // Scoreboard. Writeback retires the producer; decode issues a new one. The
  // set comes second, so it wins when both hit the same register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (wr_en) begin
        busy[a3] <= 1'b0;
      end
      if (set_en) begin
        busy[sb_addr] <= 1'b1;
      end
    end
  end

  regfile_read_port #(
    .XLEN   (XLEN),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_port1 (
    .ready    (ready),
    .addr     (a1),
    .rdata    (mem[a1]),
    .busy_bit (busy[a1]),
    .we       (we3),
    .waddr    (a3),
    .wdata    (wd3),
    .rd       (rd1),
    .busy     (busy1)
  );

  regfile_read_port #(
    .XLEN   (XLEN),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_port2 (
    .ready    (ready),
    .addr     (a2),
    .rdata    (mem[a2]),
    .busy_bit (busy[a2]),
    .we       (we3),
    .waddr    (a3),
    .wdata    (wd3),
    .rd       (rd2),
    .busy     (busy2)
  );

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb. Group A (NREG=32, BYPASS=1 and 0) runs the directed
// scenarios. Group B (NREG=16, BYPASS=1 and 0) runs a random regression
// against a reference model. Expectations go into a scoreboard queue when
// stimulus is driven and are compared on the next falling edge.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int AW_A = 5;
  localparam int AW_B = 4;
  localparam int NREG_B = 16;

  typedef enum {K_RD1, K_RD2, K_BUSY1, K_BUSY2, K_READY} kind_e;

  typedef struct {
    int          dut;
    kind_e       kind;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Group A stimulus
  logic            rst_a;
  logic [AW_A-1:0] a1_a, a2_a, a3_a, sb_addr_a;
  logic            we3_a, sb_set_a;
  logic [XLEN-1:0] wd3_a;

  // Group B stimulus
  logic            rst_b;
  logic [AW_B-1:0] a1_b, a2_b, a3_b, sb_addr_b;
  logic            we3_b, sb_set_b;
  logic [XLEN-1:0] wd3_b;

  // Outputs, indexed 0:a_byp 1:a_nob 2:b_byp 3:b_nob
  logic [XLEN-1:0] rd1_o [4];
  logic [XLEN-1:0] rd2_o [4];
  logic            busy1_o [4];
  logic            busy2_o [4];
  logic            ready_o [4];

  string names [4] = '{"a_byp", "a_nob", "b_byp", "b_nob"};

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state for group B
  bit          m_run;
  int          m_cnt;
  logic [31:0] m_reg [NREG_B];
  bit          m_busy [NREG_B];

  regfile_sb #(.XLEN(XLEN), .NREG(32), .BYPASS(1'b1)) u_a_byp (
    .clk(clk), .rst(rst_a), .a1(a1_a), .a2(a2_a), .rd1(rd1_o[0]), .rd2(rd2_o[0]),
    .we3(we3_a), .a3(a3_a), .wd3(wd3_a), .sb_set(sb_set_a), .sb_addr(sb_addr_a),
    .busy1(busy1_o[0]), .busy2(busy2_o[0]), .ready(ready_o[0])
  );

  regfile_sb #(.XLEN(XLEN), .NREG(32), .BYPASS(1'b0)) u_a_nob (
    .clk(clk), .rst(rst_a), .a1(a1_a), .a2(a2_a), .rd1(rd1_o[1]), .rd2(rd2_o[1]),
    .we3(we3_a), .a3(a3_a), .wd3(wd3_a), .sb_set(sb_set_a), .sb_addr(sb_addr_a),
    .busy1(busy1_o[1]), .busy2(busy2_o[1]), .ready(ready_o[1])
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG_B), .BYPASS(1'b1)) u_b_byp (
    .clk(clk), .rst(rst_b), .a1(a1_b), .a2(a2_b), .rd1(rd1_o[2]), .rd2(rd2_o[2]),
    .we3(we3_b), .a3(a3_b), .wd3(wd3_b), .sb_set(sb_set_b), .sb_addr(sb_addr_b),
    .busy1(busy1_o[2]), .busy2(busy2_o[2]), .ready(ready_o[2])
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG_B), .BYPASS(1'b0)) u_b_nob (
    .clk(clk), .rst(rst_b), .a1(a1_b), .a2(a2_b), .rd1(rd1_o[3]), .rd2(rd2_o[3]),
    .we3(we3_b), .a3(a3_b), .wd3(wd3_b), .sb_set(sb_set_b), .sb_addr(sb_addr_b),
    .busy1(busy1_o[3]), .busy2(busy2_o[3]), .ready(ready_o[3])
  );

  function automatic logic [31:0] observe(int dut, kind_e k);
    logic [31:0] v;
    case (k)
      K_RD1:   v = rd1_o[dut];
      K_RD2:   v = rd2_o[dut];
      K_BUSY1: v = {31'b0, busy1_o[dut]};
      K_BUSY2: v = {31'b0, busy2_o[dut]};
      K_READY: v = {31'b0, ready_o[dut]};
      default: v = 'x;
    endcase
    return v;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, expv, $time);
    end
  endtask

  task automatic push(int dut, kind_e k, logic [31:0] v);
    exp_t e;
    e.dut  = dut;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Group A expectation: first value for BYPASS=1, second for BYPASS=0
  task automatic push_a(kind_e k, logic [31:0] v_byp, logic [31:0] v_nob);
    push(0, k, v_byp);
    push(1, k, v_nob);
  endtask

  // Compare all queued expectations mid-cycle, then step past the next edge
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s.%s", names[e.dut], e.kind.name()),
            observe(e.dut, e.kind), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (group B) ----------------
  task automatic m_reset();
    m_run = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < NREG_B; i++) m_busy[i] = 1'b0;
  endtask

  task automatic m_edge();
    if (!m_run) begin
      m_reg[m_cnt] = '0;
      if (m_cnt == NREG_B - 1) m_run = 1'b1;
      m_cnt = (m_cnt + 1) % NREG_B;
    end else begin
      if (we3_b && a3_b != 0) begin
        m_reg[a3_b]  = wd3_b;
        m_busy[a3_b] = 1'b0;
      end
      if (sb_set_b && sb_addr_b != 0) m_busy[sb_addr_b] = 1'b1;
    end
  endtask

  function automatic logic [31:0] m_rd(logic [AW_B-1:0] a, bit byp);
    bit hit;
    hit = m_run && we3_b && (a3_b == a) && (a3_b != 0);
    if (!m_run || a == 0) return '0;
    if (byp && hit) return wd3_b;
    return m_reg[a];
  endfunction

  function automatic logic [31:0] m_bz(logic [AW_B-1:0] a, bit byp);
    bit hit;
    hit = m_run && we3_b && (a3_b == a) && (a3_b != 0);
    if (!m_run || a == 0) return '0;
    return {31'b0, m_busy[a] && !(byp && hit)};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_a = 1'b0; a1_a = '0; a2_a = '0; a3_a = '0; sb_addr_a = '0;
    we3_a = 1'b0; sb_set_a = 1'b0; wd3_a = '0;
    rst_b = 1'b0; a1_b = '0; a2_b = '0; a3_b = '0; sb_addr_b = '0;
    we3_b = 1'b0; sb_set_b = 1'b0; wd3_b = '0;
    for (int i = 0; i < NREG_B; i++) m_reg[i] = '0;
    m_reset();
    @(posedge clk);
    #1;

    // Reset state
    a1_a = 5'd5; a2_a = 5'd5;
    push_a(K_READY, 0, 0); push_a(K_RD1, 0, 0); push_a(K_BUSY1, 0, 0);
    cycle();

    // Clear sequence: a write attempted throughout CLEAR must be dropped
    rst_a = 1'b1; we3_a = 1'b1; a3_a = 5'd5; wd3_a = 32'hB;
    for (int i = 0; i < 32; i++) begin
      push_a(K_READY, 0, 0); push_a(K_RD1, 0, 0);
      cycle();
    end
    we3_a = 1'b0;
    push_a(K_READY, 1, 1); push_a(K_RD1, 0, 0);
    cycle();

    // Basic write then read
    we3_a = 1'b1; a3_a = 5'd5; wd3_a = 32'h0000000B; a1_a = 5'd1; a2_a = 5'd2;
    cycle();
    a3_a = 5'd6; wd3_a = 32'h0000000A;
    cycle();
    we3_a = 1'b0; a1_a = 5'd5; a2_a = 5'd6;
    push_a(K_RD1, 32'hB, 32'hB); push_a(K_RD2, 32'hA, 32'hA);
    cycle();

    // Register 0 ignores writes
    we3_a = 1'b1; a3_a = 5'd0; wd3_a = 32'hFFFFFFFF; a1_a = 5'd0; a2_a = 5'd0;
    push_a(K_RD1, 0, 0); push_a(K_RD2, 0, 0);
    cycle();
    we3_a = 1'b0;
    push_a(K_RD1, 0, 0);
    cycle();

    // Same-cycle bypass to both ports
    we3_a = 1'b1; a3_a = 5'd7; wd3_a = 32'h1234; a1_a = 5'd7; a2_a = 5'd7;
    push_a(K_RD1, 32'h1234, 0); push_a(K_RD2, 32'h1234, 0);
    cycle();
    we3_a = 1'b0;
    push_a(K_RD1, 32'h1234, 32'h1234); push_a(K_RD2, 32'h1234, 32'h1234);
    cycle();

    // Scoreboard set, visible next cycle
    sb_set_a = 1'b1; sb_addr_a = 5'd9; a1_a = 5'd9; a2_a = 5'd9;
    push_a(K_BUSY1, 0, 0);
    cycle();
    sb_set_a = 1'b0;
    push_a(K_BUSY1, 1, 1); push_a(K_BUSY2, 1, 1);
    cycle();
    // Retiring write masks busy only with bypass
    we3_a = 1'b1; a3_a = 5'd9; wd3_a = 32'h99;
    push_a(K_BUSY1, 0, 1); push_a(K_BUSY2, 0, 1); push_a(K_RD1, 32'h99, 0);
    cycle();
    we3_a = 1'b0;
    push_a(K_BUSY1, 0, 0); push_a(K_RD1, 32'h99, 32'h99);
    cycle();
    // Set and write together: set wins
    sb_set_a = 1'b1; sb_addr_a = 5'd9; we3_a = 1'b1; a3_a = 5'd9; wd3_a = 32'h77;
    push_a(K_BUSY1, 0, 0);
    cycle();
    sb_set_a = 1'b0; we3_a = 1'b0;
    push_a(K_BUSY1, 1, 1); push_a(K_RD1, 32'h77, 32'h77);
    cycle();
    // Setting an already-busy register keeps it busy
    sb_set_a = 1'b1; sb_addr_a = 5'd9;
    cycle();
    sb_set_a = 1'b0;
    push_a(K_BUSY1, 1, 1);
    cycle();
    // Scoreboard set on register 0 is dropped
    sb_set_a = 1'b1; sb_addr_a = 5'd0; a1_a = 5'd0; a2_a = 5'd0;
    cycle();
    sb_set_a = 1'b0;
    push_a(K_BUSY1, 0, 0); push_a(K_BUSY2, 0, 0);
    cycle();

    // Reset mid-operation
    we3_a = 1'b1; a3_a = 5'd3; wd3_a = 32'h55; sb_set_a = 1'b1; sb_addr_a = 5'd3;
    a1_a = 5'd3; a2_a = 5'd3;
    cycle();
    we3_a = 1'b0; sb_set_a = 1'b0;
    push_a(K_RD1, 32'h55, 32'h55); push_a(K_BUSY1, 1, 1);
    cycle();
    rst_a = 1'b0;
    push_a(K_RD1, 0, 0); push_a(K_RD2, 0, 0); push_a(K_BUSY1, 0, 0);
    push_a(K_BUSY2, 0, 0); push_a(K_READY, 0, 0);
    cycle();
    rst_a = 1'b1;
    for (int i = 0; i < 32; i++) begin
      push_a(K_READY, 0, 0);
      cycle();
    end
    push_a(K_READY, 1, 1); push_a(K_RD1, 0, 0); push_a(K_BUSY1, 0, 0);
    cycle();

    // Reset during CLEAR at cnt=10: the clear restarts from scratch
    rst_a = 1'b0;
    cycle();
    rst_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_a(K_READY, 0, 0);
      cycle();
    end
    rst_a = 1'b0;
    push_a(K_READY, 0, 0); push_a(K_RD1, 0, 0);
    cycle();
    rst_a = 1'b1;
    for (int i = 0; i < 32; i++) begin
      push_a(K_READY, 0, 0);
      cycle();
    end
    push_a(K_READY, 1, 1); push_a(K_RD1, 0, 0);
    cycle();

    // Random regression on group B against the model
    rst_b = 1'b0;
    m_reset();
    cycle();
    for (int c = 0; c < 10000; c++) begin
      rst_b     = ($urandom_range(0, 999) != 0);
      we3_b     = 1'($urandom_range(0, 1));
      a3_b      = AW_B'($urandom_range(0, NREG_B - 1));
      wd3_b     = $urandom();
      sb_set_b  = 1'($urandom_range(0, 1));
      sb_addr_b = AW_B'($urandom_range(0, NREG_B - 1));
      a1_b      = ($urandom_range(0, 3) == 0) ? a3_b : AW_B'($urandom_range(0, NREG_B - 1));
      a2_b      = ($urandom_range(0, 3) == 0) ? a3_b : AW_B'($urandom_range(0, NREG_B - 1));
      if (!rst_b) m_reset();
      for (int d = 2; d < 4; d++) begin
        push(d, K_RD1,   m_rd(a1_b, d == 2));
        push(d, K_RD2,   m_rd(a2_b, d == 2));
        push(d, K_BUSY1, m_bz(a1_b, d == 2));
        push(d, K_BUSY2, m_bz(a2_b, d == 2));
        push(d, K_READY, {31'b0, m_run});
      end
      cycle();
      if (rst_b) m_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends on its own
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "time limit reached");
  end

endmodule : tb_regfile_sb
